// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one product or quotient bit per cycle,
// with a fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(XLEN - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  logic              is_mul, sign_a, sign_b, div0, ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     msum, rem_sh, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_res;

  assign is_mul = ~op_q[2];
  assign sign_a = a_q[XLEN-1] & (op_q == OP_MULH || op_q == OP_MULHSU ||
                                 op_q == OP_DIV  || op_q == OP_REM);
  assign sign_b = b_q[XLEN-1] & (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM);
  assign a_mag  = sign_a ? -a_q : a_q;
  assign b_mag  = sign_b ? -b_q : b_q;
  assign div0   = op_q[2] && (b_q == '0);
  assign ovf    = (op_q == OP_DIV || op_q == OP_REM) &&
                  (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

  // After PREP, a_q holds the multiplicand (multiply) or divisor (divide) magnitude.
  assign msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign rem_sh = {rem_q, acc_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, a_q};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rmd  = neg_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = rmd;
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo;
      default:                      fix_res = rmd;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: if (valid_i && !flush_i) begin
        state_d = S_PREP;
        op_d    = op_i;
        a_d     = rs1_i;
        b_d     = rs2_i;
      end
      S_PREP: if (div0 || ovf) begin
        acc_d   = {{XLEN{1'b0}}, (div0 ? {XLEN{1'b1}} : a_q)};
        rem_d   = div0 ? a_q : '0;
        neg_d   = 1'b0;
        state_d = S_FIX;
      end else begin
        a_d     = is_mul ? a_mag : b_mag;
        acc_d   = {{XLEN{1'b0}}, (is_mul ? b_mag : a_mag)};
        rem_d   = '0;
        neg_d   = (!is_mul && op_q[1]) ? sign_a : (sign_a ^ sign_b);
        cnt_d   = CNT_MAX;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (is_mul) begin
          acc_d = {msum, acc_q[XLEN-1:1]};
        end else begin
          rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~diff[XLEN]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply/divide execution unit with a valid/ready request handshake. It is parametrised in datapath width. It sits beside the ALU in the execute stage: operands arrive from the register file and funct3 from the instruction, and the result is written back to rd. It computes one quotient or partial-product bit per cycle, with a fast path for the division corner cases.

## Interface
- XLEN, 32, operand/result width; legal values ≥ 4
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request (high only in IDLE)
- op_i  in  3  RISC-V funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  XLEN  operand A (multiplicand/dividend)
- rs2_i  in  XLEN  operand B (multiplier/divisor)
- flush_i  in  1  synchronous abort of the current operation
- busy_o  out  1  operation in progress (state ≠ IDLE)
- valid_o  out  1  one-cycle pulse: result_o is new
- result_o  out  XLEN  result; holds the last completed value

## Operation
- Accept on a rising edge where valid_i && ready_o && !flush_i. op_i, rs1_i and rs2_i are registered at that edge. Inputs are ignored at all other times.
- States:
  - IDLE → PREP on accept.
  - PREP → CALC, or → FIX on the special-case fast path.
  - CALC: XLEN cycles, counter counts down XLEN-1 → 0, then → FIX.
  - FIX → DONE.
  - DONE → IDLE.
- PREP:
  - Determine signedness per op. MULH and DIV/REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Form magnitudes (two's complement negation of negative signed operands).
  - Record result sign. Multiply: sA^sB. Quotient: sA^sB. Remainder: sA.
- CALC, multiply: shift-add on a 2·XLEN accumulator of magnitudes. Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half, then shift right by 1 (the carry enters the MSB).
- CALC, divide: restoring division on an XLEN+1-bit partial remainder. Each cycle:
  - Shift in the next dividend MSB.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise the quotient bit is 0.
- FIX:
  - Negate the magnitude result if the recorded sign is 1.
  - Select the output. MUL gives the low XLEN bits of the product. MULH/MULHSU/MULHU give the high XLEN bits. DIV/DIVU give the quotient. REM/REMU give the remainder.
  - Load result_o.
- Fast path, decided in PREP and bypassing CALC:
  - Divide by zero (rs2 = 0, all divide ops): quotient = all ones; remainder = rs1 unmodified.
  - Signed overflow (DIV/REM, rs1 = 1<<(XLEN-1), rs2 = all ones): quotient = rs1; remainder = 0.
- DONE: valid_o = 1 for exactly one cycle. result_o stays stable until the next FIX.
- flush_i:
  - In any non-IDLE state, the next edge goes to IDLE. valid_o is not asserted and result_o is unchanged.
  - In IDLE, flush_i blocks acceptance.
  - Flush in DONE: the pulse in that cycle is still visible (the combinational view of state), and the state returns to IDLE.
- Reset (async, any time, including mid-operation) clears immediately:
  - state = IDLE
  - ready_o = 1, busy_o = 0, valid_o = 0
  - result_o = 0
  - counter = 0

## Timing
- The accept edge is E0.
- Normal path:
  - PREP in cycle 1, CALC in cycles 2 … XLEN+1, FIX in cycle XLEN+2.
  - valid_o is high in cycle XLEN+3 (35 for XLEN = 32).
- Fast path: PREP in cycle 1, FIX in cycle 2, valid_o in cycle 3.
- ready_o is low from E0 through DONE, and high again in the cycle after DONE. Back-to-back issue is therefore XLEN+4 cycles per op.
- valid_o and result_o are registered outputs. ready_o and busy_o decode from the state register only; they have no combinational path from any input.
- No throughput overlap: one operation in flight at most.

## Test plan
- Multiply (XLEN = 32):
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, with valid_o exactly in cycle 35 and ready_o low in cycles 1–35.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
  - REM 7 / 0xFFFFFFFE → 1.
- Corner cases (valid_o required in cycle 3):
  - DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Flush:
  - Issue DIVU, assert flush_i in cycle 10 → no valid_o, ready_o = 1 in cycle 11, result_o unchanged.
  - A following MUL 3 × 4 → 12 at the normal latency.
- Reset: assert rst_i asynchronously mid-CALC → result_o = 0, valid_o = 0, ready_o = 1 before the next edge. Release, then run MULHU 2 × 3 → 0.
- Handshake: hold valid_i high continuously with changing operands → only operands present at ready_o-high edges are accepted. Issue 100 random ops at XLEN = 32 and XLEN = 8 and compare every result against a reference model.
